// File: rtl/seq_muldiv_pkg.sv
// Shared opcode constants and FSM state encoding for the sequential multiply/divide unit.
package seq_muldiv_pkg;

    localparam logic [4:0] ALU_MUL = 5'b01110;
    localparam logic [4:0] ALU_DIV = 5'b01111;

    typedef enum logic [2:0] {
        IDLE,
        MUL,
        DIV,
        FIX,
        DONE
    } state_t;

endpackage

// File: rtl/seq_muldiv_if.sv
// Operand/handshake/result bundle between the control unit (master) and seq_muldiv (slave).
interface seq_muldiv_if #(
    parameter int WIDTH = 32
);

    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [4:0]       ALU_ctl;
    logic             start;
    logic             busy;
    logic             done;
    logic             div0;
    logic [WIDTH-1:0] Zhigh;
    logic [WIDTH-1:0] Zlow;

    modport master (
        output A, B, ALU_ctl, start,
        input  busy, done, div0, Zhigh, Zlow
    );

    modport slave (
        input  A, B, ALU_ctl, start,
        output busy, done, div0, Zhigh, Zlow
    );

endinterface

// File: rtl/seq_muldiv_step.sv
// One iteration of either a radix-2 Booth multiply step or a restoring divide step.
module muldiv_step #(
    parameter int WIDTH = 32
) (
    input  logic               mode_div,
    input  logic [2*WIDTH:0]   work,
    input  logic [WIDTH-1:0]   operand,
    output logic [2*WIDTH:0]   next_work
);

    logic [WIDTH:0] acc_ext;
    logic [WIDTH:0] m_ext;
    logic [WIDTH:0] booth_sum;
    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    // Booth sum is one bit wider so its true sign survives the arithmetic shift,
    // which keeps the most negative multiplicand exact.
    always_comb begin
        acc_ext = {work[2*WIDTH], work[2*WIDTH:WIDTH+1]};
        m_ext   = {operand[WIDTH-1], operand};
        case (work[1:0])
            2'b01:   booth_sum = acc_ext + m_ext;
            2'b10:   booth_sum = acc_ext - m_ext;
            default: booth_sum = acc_ext;
        endcase
        shifted = {work[2*WIDTH:WIDTH+1], work[WIDTH]};
        diff    = shifted - {1'b0, operand};
        if (!mode_div) begin
            next_work = {booth_sum, work[WIDTH:1]};
        end else if (!diff[WIDTH]) begin
            next_work = {diff[WIDTH-1:0], work[WIDTH-1:1], 1'b1, 1'b0};
        end else begin
            next_work = {shifted[WIDTH-1:0], work[WIDTH-1:1], 1'b0, 1'b0};
        end
    end

endmodule

// File: rtl/seq_muldiv.sv
// Multi-cycle signed multiply/divide unit producing the Zhigh/Zlow register pair.
import seq_muldiv_pkg::*;

module seq_muldiv #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic        clk,
    input  logic        clr,
    seq_muldiv_if.slave bus
);

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [2*WIDTH:0]   work;
    logic [2*WIDTH:0]   step_out;
    logic [WIDTH-1:0]   operand;
    logic               mode_div;
    logic               a_neg;
    logic               q_neg;
    logic               div0_pend;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [WIDTH-1:0]   rem;
    logic [WIDTH-1:0]   quo;

    assign a_mag = bus.A[WIDTH-1] ? -bus.A : bus.A;
    assign b_mag = bus.B[WIDTH-1] ? -bus.B : bus.B;
    assign rem   = work[2*WIDTH:WIDTH+1];
    assign quo   = work[WIDTH:1];

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .mode_div  (mode_div),
        .work      (work),
        .operand   (operand),
        .next_work (step_out)
    );

    // busy/done are registered views of the state, giving one cycle of lag behind it.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state     <= IDLE;
            cnt       <= '0;
            work      <= '0;
            operand   <= '0;
            mode_div  <= 1'b0;
            a_neg     <= 1'b0;
            q_neg     <= 1'b0;
            div0_pend <= 1'b0;
            bus.busy  <= 1'b0;
            bus.done  <= 1'b0;
            bus.div0  <= 1'b0;
            bus.Zhigh <= '0;
            bus.Zlow  <= '0;
        end else begin
            bus.busy <= (state != IDLE);
            bus.done <= (state == DONE);
            case (state)
                IDLE: begin
                    if (bus.start && (bus.ALU_ctl == ALU_MUL || bus.ALU_ctl == ALU_DIV)) begin
                        bus.div0 <= 1'b0;
                        cnt      <= '0;
                        a_neg    <= bus.A[WIDTH-1];
                        q_neg    <= bus.A[WIDTH-1] ^ bus.B[WIDTH-1];
                        if (bus.ALU_ctl == ALU_MUL) begin
                            mode_div  <= 1'b0;
                            operand   <= bus.A;
                            work      <= {{WIDTH{1'b0}}, bus.B, 1'b0};
                            div0_pend <= 1'b0;
                            state     <= MUL;
                        end else if (bus.B == '0) begin
                            mode_div  <= 1'b1;
                            operand   <= '0;
                            work      <= {bus.A, {WIDTH{1'b1}}, 1'b0};
                            div0_pend <= 1'b1;
                            state     <= DONE;
                        end else begin
                            mode_div  <= 1'b1;
                            operand   <= b_mag;
                            work      <= {{WIDTH{1'b0}}, a_mag, 1'b0};
                            div0_pend <= 1'b0;
                            state     <= DIV;
                        end
                    end
                end
                MUL, DIV: begin
                    work <= step_out;
                    cnt  <= cnt + 1'b1;
                    if (cnt == CNT_W'(WIDTH - 1)) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    if (mode_div) begin
                        work <= {a_neg ? -rem : rem, q_neg ? -quo : quo, 1'b0};
                    end
                    state <= DONE;
                end
                DONE: begin
                    bus.Zhigh <= rem;
                    bus.Zlow  <= quo;
                    bus.div0  <= div0_pend;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_muldiv.sv
// Scoreboard bench for seq_muldiv: driver pushes reference results, monitor checks them on done.
module tb_seq_muldiv;
    import seq_muldiv_pkg::*;

    localparam int WIDTH = 32;

    typedef struct {
        logic [31:0] zhi;
        logic [31:0] zlo;
        logic        div0;
        int          done_cyc;
        int          busy_len;
        string       name;
    } exp_t;

    logic  clk = 1'b0;
    logic  clr;
    int    cyc = 0;
    int    tests = 0;
    int    fails = 0;
    int    busy_run = 0;
    logic [31:0] last_zlo = '0;
    exp_t  scoreboard[$];

    seq_muldiv_if #(.WIDTH(WIDTH)) bus();

    seq_muldiv #(.WIDTH(WIDTH), .CNT_W(6)) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic check_output(string name, logic [63:0] act, logic [63:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic print_summary();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
    endtask

    // Reference results come straight from signed 64-bit arithmetic.
    function automatic exp_t model(string name, logic [31:0] a, logic [31:0] b,
                                   logic [4:0] op, int acc);
        exp_t   e;
        longint sa, sbv, p, q, r;
        sa  = $signed(a);
        sbv = $signed(b);
        e.name = name;
        if (op == ALU_MUL) begin
            p = sa * sbv;
            e.zhi = p[63:32];
            e.zlo = p[31:0];
            e.div0 = 1'b0;
            e.done_cyc = acc + 34;
            e.busy_len = 34;
        end else if (b == 32'd0) begin
            e.zhi = a;
            e.zlo = 32'hFFFF_FFFF;
            e.div0 = 1'b1;
            e.done_cyc = acc + 1;
            e.busy_len = 1;
        end else begin
            q = sa / sbv;
            r = sa % sbv;
            e.zhi = r[31:0];
            e.zlo = q[31:0];
            e.div0 = 1'b0;
            e.done_cyc = acc + 34;
            e.busy_len = 34;
        end
        return e;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (clr) busy_run = 0;
        else if (bus.busy) busy_run++;
        else busy_run = 0;
        if (bus.done) begin
            if (scoreboard.size() == 0) begin
                tests++;
                fails++;
                $display("[TB] FAIL unexpected_done: got done=1 at cycle %0d, expected no done", cyc);
            end else begin
                e = scoreboard.pop_front();
                check_output({e.name, "_zhigh"}, 64'(bus.Zhigh), 64'(e.zhi));
                check_output({e.name, "_zlow"},  64'(bus.Zlow),  64'(e.zlo));
                check_output({e.name, "_div0"},  64'(bus.div0),  64'(e.div0));
                check_output({e.name, "_cycle"}, 64'(cyc),       64'(e.done_cyc));
                check_output({e.name, "_busylen"}, 64'(busy_run), 64'(e.busy_len));
            end
        end
    end

    task automatic wait_done(string name, int limit);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.done && n < limit);
        if (!bus.done) begin
            tests++;
            fails++;
            $display("[TB] FAIL %s_timeout: got no done in %0d cycles, expected done", name, limit);
        end
    endtask

    // Issues one operation from an idle unit, scrambles the inputs afterwards and
    // optionally pokes start mid-operation before waiting for completion.
    task automatic apply_stimulus(string name, logic [31:0] a, logic [31:0] b,
                                  logic [4:0] op, int poke);
        exp_t e;
        bus.A = a;
        bus.B = b;
        bus.ALU_ctl = op;
        bus.start = 1'b1;
        e = model(name, a, b, op, cyc + 1);
        scoreboard.push_back(e);
        last_zlo = e.zlo;
        @(negedge clk);
        bus.start = 1'b0;
        bus.A = $urandom;
        bus.B = $urandom;
        bus.ALU_ctl = ($urandom_range(0, 1) == 1) ? ALU_MUL : ALU_DIV;
        if (poke > 0) begin
            repeat (poke) @(negedge clk);
            bus.start = 1'b1;
            @(negedge clk);
            bus.start = 1'b0;
        end
        wait_done(name, 60);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: got no finish by time %0t, expected completion", $time);
        print_summary();
        $finish;
    end

    initial begin
        exp_t e;
        logic [31:0] ra, rb;
        logic [4:0]  rop;

        clr = 1'b1;
        bus.A = '0;
        bus.B = '0;
        bus.ALU_ctl = '0;
        bus.start = 1'b0;
        repeat (2) @(negedge clk);
        check_output("reset_busy",  64'(bus.busy),  64'd0);
        check_output("reset_done",  64'(bus.done),  64'd0);
        check_output("reset_div0",  64'(bus.div0),  64'd0);
        check_output("reset_zhigh", 64'(bus.Zhigh), 64'd0);
        check_output("reset_zlow",  64'(bus.Zlow),  64'd0);
        clr = 1'b0;
        @(negedge clk);

        apply_stimulus("mul_7_m3",     32'd7,          32'hFFFF_FFFD, ALU_MUL, 0);
        apply_stimulus("mul_min_min",  32'h8000_0000,  32'h8000_0000, ALU_MUL, 0);
        apply_stimulus("div_m17_5",    32'hFFFF_FFEF,  32'd5,         ALU_DIV, 0);
        apply_stimulus("div_min_m1",   32'h8000_0000,  32'hFFFF_FFFF, ALU_DIV, 0);
        apply_stimulus("div_by_zero",  32'h1234_5678,  32'd0,         ALU_DIV, 0);

        // Abort a multiply with an asynchronous clear partway through.
        bus.A = 32'd100;
        bus.B = 32'd200;
        bus.ALU_ctl = ALU_MUL;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (10) @(negedge clk);
        clr = 1'b1;
        #1;
        check_output("abort_busy",  64'(bus.busy),  64'd0);
        check_output("abort_done",  64'(bus.done),  64'd0);
        check_output("abort_div0",  64'(bus.div0),  64'd0);
        check_output("abort_zhigh", 64'(bus.Zhigh), 64'd0);
        check_output("abort_zlow",  64'(bus.Zlow),  64'd0);
        @(negedge clk);
        clr = 1'b0;
        repeat (40) @(negedge clk);
        check_output("abort_no_busy", 64'(bus.busy), 64'd0);

        apply_stimulus("mul_6_7",      32'd6,          32'd7,         ALU_MUL, 0);
        apply_stimulus("div_poke",     32'd1000,       32'hFFFF_FFF9, ALU_DIV, 10);

        bus.A = 32'd55;
        bus.B = 32'd3;
        bus.ALU_ctl = 5'b00011;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (40) @(negedge clk);
        check_output("badop_busy", 64'(bus.busy), 64'd0);
        check_output("badop_zlow", 64'(bus.Zlow), 64'(last_zlo));

        // Start held high: second operation is accepted right after the first finishes.
        bus.A = 32'h0001_0003;
        bus.B = 32'hFFFF_0005;
        bus.ALU_ctl = ALU_MUL;
        bus.start = 1'b1;
        e = model("b2b_first", 32'h0001_0003, 32'hFFFF_0005, ALU_MUL, cyc + 1);
        scoreboard.push_back(e);
        e = model("b2b_second", 32'hFFFF_FF9C, 32'd7, ALU_DIV, cyc + 36);
        scoreboard.push_back(e);
        @(negedge clk);
        bus.A = 32'hFFFF_FF9C;
        bus.B = 32'd7;
        bus.ALU_ctl = ALU_DIV;
        wait_done("b2b_first", 60);
        @(negedge clk);
        bus.start = 1'b0;
        wait_done("b2b_second", 60);

        for (int i = 0; i < 20; i++) begin
            ra  = $urandom;
            rb  = $urandom;
            if ($urandom_range(0, 3) == 0) ra = ra >> $urandom_range(0, 31);
            if ($urandom_range(0, 3) == 0) rb = rb >> $urandom_range(0, 31);
            rop = ($urandom_range(0, 1) == 1) ? ALU_MUL : ALU_DIV;
            if (rop == ALU_DIV && $urandom_range(0, 7) == 0) rb = 32'd0;
            apply_stimulus($sformatf("rand%0d", i), ra, rb, rop, 0);
        end

        repeat (5) @(negedge clk);
        if (scoreboard.size() != 0) begin
            tests++;
            fails++;
            $display("[TB] FAIL leftover: got %0d pending results, expected 0", scoreboard.size());
        end
        print_summary();
        $finish;
    end

endmodule

// File: doc/seq_muldiv.md
# seq_muldiv

Multi-cycle signed multiply/divide unit that feeds the 64-bit Z register pair (Zhigh/Zlow) in the datapath.
- Used for the Multiply and Divide opcodes in place of the single-cycle combinational multiplier/divider, trading 34 cycles of latency for far less logic.
- The control unit starts an operation with a start pulse, waits for done, then asserts Zhigh/Zlow load enables in the done cycle.

## Interface
Parameters:
- WIDTH, 32, operand width; results are 2*WIDTH split into Zhigh/Zlow.
- CNT_W, 6, iteration counter width (must hold WIDTH).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- clr  in  1  reset; **one clock; reset is asynchronous and active-high**; forces the IDLE state and clears all registers and outputs.
- A  in  WIDTH  operand A (multiplicand / dividend), two's complement.
- B  in  WIDTH  operand B (multiplier / divisor), two's complement.
- ALU_ctl  in  5  opcode:
  - 5'b01110 Multiply
  - 5'b01111 Divide
  - all other codes are ignored.
- start  in  1  request pulse; sampled only in IDLE.
- busy  out  1  high from the cycle after start is accepted until done falls.
- done  out  1  one-cycle pulse; Zhigh/Zlow are valid in this cycle.
- div0  out  1  set with done when a Divide had B==0; cleared at next accepted start.
- Zhigh  out  WIDTH  Multiply: product[63:32]; Divide: remainder.
- Zlow  out  WIDTH  Multiply: product[31:0]; Divide: quotient.

## Operation
- States and transitions:
  - IDLE -> MUL on start with Multiply.
  - IDLE -> DIV on start with Divide and B!=0.
  - IDLE -> DONE on start with Divide and B==0.
  - MUL/DIV -> FIX after WIDTH iterations.
  - FIX -> DONE.
  - DONE -> IDLE.
- Start acceptance: A, B and ALU_ctl are latched on the accepting edge. Later changes on A, B or ALU_ctl have no effect until the next accepted start.
- Multiply: radix-2 Booth, one step per cycle, with a 65-bit {acc, multiplier, q-1} register and arithmetic right shift. FIX passes the result through unchanged.
- Divide:
  - Restoring division on magnitudes |A| and |B|, one quotient bit per cycle.
  - FIX negates the quotient if sign(A)!=sign(B), and negates the remainder if A<0.
  - Quotient truncates toward zero; the remainder takes the sign of the dividend.
- Arithmetic boundaries:
  - 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000 and remainder 0 (the overflow wraps; no flag).
  - Magnitude of 0x80000000 is handled as unsigned 2^31.
- Divide by zero: Zlow=32'hFFFFFFFF, Zhigh=A, div0=1.
- Ignored starts:
  - start while busy is ignored.
  - start with any other opcode in IDLE is ignored (no busy, no done).
- Output holding: Zhigh/Zlow keep the last result until the next operation reaches DONE. They are not disturbed during MUL/DIV.

## Timing
- Reset values: busy=0, done=0, div0=0, Zhigh=0, Zlow=0, state=IDLE.
- clr may assert mid-operation. It aborts immediately (asynchronously); no done is produced for the aborted operation.
- Normal latency: start accepted at edge 0; iterations on edges 1..32; FIX at edge 33; DONE at edge 34.
  - done=1 and new Zhigh/Zlow are visible in the cycle following edge 34.
  - The unit returns to IDLE at edge 35.
  - busy is high from edge 1 through the DONE cycle.
- Divide-by-zero latency: done is visible after edge 1.
- Back-to-back operation: the earliest next start is accepted at edge 35 (start may be held high). Throughput is one operation per 35 cycles.
- done is a registered output and never combinational from start.

## Structure
- Shared package (alongside the ALU opcode constants) holds:
  - the Multiply/Divide ALU_ctl codes
  - the state enum: IDLE, MUL, DIV, FIX, DONE.
- The FSM, counter and handshake live in seq_muldiv.
- One sub-module, muldiv_step, holds the combinational single-iteration logic (Booth add/sub-shift, restoring subtract-shift) selected by a mode bit.

## Test plan
- Multiply A=7, B=-3: after 34 cycles done=1, Zhigh=FFFFFFFF, Zlow=FFFFFFEB; busy for exactly 34 cycles.
- Multiply A=B=80000000: Zhigh=40000000, Zlow=00000000.
- Divide A=-17, B=5: Zlow=FFFFFFFD, Zhigh=FFFFFFFE.
- Divide A=80000000, B=FFFFFFFF: Zlow=80000000, Zhigh=0, div0=0.
- Divide A=12345678, B=0: done after 1 cycle, Zlow=FFFFFFFF, Zhigh=12345678, div0=1.
- Reset and start/opcode handling:
  - Start multiply, pulse clr at cycle 10: outputs 0, busy 0, no done.
  - A new start with A=6, B=7 then gives Zlow=0000002A.
  - A start pulse mid-operation is ignored.
  - start with ALU_ctl=00011 is ignored.
